// File: rtl/shifter_pkg.sv
// Shared constants for the sequential shifter: default width, op codes and FSM state encodings.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [1:0] op_t;

  localparam op_t OP_LSL = 2'b00;
  localparam op_t OP_LSR = 2'b01;
  localparam op_t OP_ASR = 2'b10;
  localparam op_t OP_ROT = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift step. Rotate exists only with SEQ_SHIFTER_ROTATE_EN defined;
// otherwise op=11 falls through to LSL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] w_next
);

  always_comb begin
    w_next = {w[WIDTH-2:0], 1'b0};
    case (op)
      OP_LSR: w_next = {1'b0, w[WIDTH-1:1]};
      OP_ASR: w_next = {w[WIDTH-1], w[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROT: w_next = {w[WIDTH-2:0], w[WIDTH-1]};
`else
      OP_ROT: w_next = {w[WIDTH-2:0], 1'b0};
`endif
      default: w_next = {w[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per SHIFT cycle, result and overflow registered on entry to DONE.
// Optional rotate via SEQ_SHIFTER_ROTATE_EN (see shift_step).
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             OF,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [1:0]       op_q;
  logic [4:0]       cnt_q;
  logic             sign_q;

  // Only the low five bits of B form the shift count.
  logic unused_b;
  assign unused_b = ^B[WIDTH-1:5];

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .w      (w_q),
    .op     (op_q),
    .w_next (w_next)
  );

  assign busy = (state_q == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      op_q    <= OP_LSL;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      Y       <= '0;
      OF      <= 1'b0;
      done    <= 1'b0;
    end else begin
      // done trails DONE by one cycle so it lands N+1 cycles after acceptance.
      done <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            w_q    <= A;
            op_q   <= op;
            cnt_q  <= B[4:0];
            sign_q <= A[WIDTH-1];
            if (B[4:0] == 5'd0) begin
              state_q <= ST_DONE;
              Y       <= A;
              OF      <= 1'b0;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          w_q   <= w_next;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= ST_DONE;
            Y       <= w_next;
            OF      <= sign_q ^ w_next[WIDTH-1];
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
